prog_truth_table: RTL and testbench
===================================

PROG_TRUTH_TABLE -- requirements
Module: prog_truth_table

Interface
REQ-001 Param N_IN, default 3: number of logic inputs, legal range 1..6.
REQ-002 Param RESET_TABLE, default 8'hBE (width 2**N_IN): truth table loaded at reset.
REQ-003 Param SETTLE, default 4: consecutive differing samples needed to flip out, only when LUT_SETTLE_EN is defined; legal range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_valid  in  1  serial table bit offered.
REQ-007 cfg_bit  in  1  table bit, MSB first.
REQ-008 cfg_ready  out  1  shifter can accept a bit.
REQ-009 cfg_done  out  1  one-cycle pulse: new table committed.
REQ-010 in_valid  in  1  evaluation request.
REQ-011 in_bits  in  N_IN  input vector; in_bits[N_IN-1] is the first input (MSB of index).
REQ-012 out_valid  out  1  evaluation result valid.
REQ-013 out  out  1  registered logic output.

Function
REQ-014 Table mapping SHALL be: index = in_bits as unsigned; raw = table[2**N_IN-1-index] (all-zero input selects MSB).
REQ-015 With RESET_TABLE=8'hBE, raw SHALL be 1 for indices 0,2,3,4,5,6 and 0 for indices 1,7.
REQ-016 Eval latency SHALL be 1 cycle: out_valid(t+1)=in_valid(t); out updates only on cycles where in_valid=1.
REQ-017 out and out_valid SHALL be driven only from registers, never combinationally from inputs.
REQ-018 Load FSM SHALL have states IDLE, LOAD, COMMIT.
REQ-019 A bit is accepted when cfg_valid && cfg_ready; accepted bits shift left into a shadow register (LSB in), bit counter increments.
REQ-020 IDLE->LOAD on first accepted bit; LOAD->COMMIT when the 2**N_IN-th bit is accepted; COMMIT->IDLE unconditionally after one cycle.
REQ-021 cfg_ready SHALL be 1 in IDLE and LOAD, 0 in COMMIT.
REQ-022 In COMMIT, active table <= shadow, counter <= 0, cfg_done = 1 for exactly that cycle.
REQ-023 Evaluations SHALL use the old active table through the COMMIT cycle; the new table applies from the cycle after cfg_done.
REQ-024 cfg_valid low in LOAD SHALL stall without losing partial shadow contents; no timeout.
REQ-025 Loading and evaluation SHALL proceed concurrently with no mutual stalls.

Reset
REQ-026 On rst: state=IDLE, counter=0, shadow=0, active table=RESET_TABLE, cfg_ready=1, cfg_done=0, out_valid=0, out=0, settle counter=0.
REQ-027 rst asserted mid-load SHALL discard partial shadow and restore RESET_TABLE, overriding any simultaneous cfg or eval activity.
REQ-028 cfg_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro LUT_SETTLE_EN SHALL enable output settling filter.
REQ-030 Defined: out flips only after SETTLE consecutive in_valid samples with raw != out; any sample with raw == out clears the settle counter; out_valid still follows REQ-016.
REQ-031 Defined: a table commit SHALL clear the settle counter.
REQ-032 Undefined: out = raw of the latest valid sample (REQ-016), no settle counter, SETTLE ignored.

Verification
REQ-033 Reset default: after rst, sweep in_bits 0..7 with in_valid=1 -> out sequence 1,0,1,1,1,1,1,0, each one cycle later.
REQ-034 Load: shift 8 bits of 8'h96 with no gaps -> cfg_done pulses once on the cycle after the 8th bit; sweep 0..7 -> 1,0,0,1,0,1,1,0.
REQ-035 Stalled load: 8'h01 with cfg_valid low for 3 cycles after bit 4 -> identical result to gapless load; input 7 -> 1, others 0.
REQ-036 Commit boundary: in_valid=1, in_bits=0 held continuously across load of 8'h00 -> out=1 through the cycle after COMMIT, 0 afterwards.
REQ-037 Reset mid-load: rst after 5 bits of 8'h00 -> cfg_done never pulses; input 0 -> out=1 (RESET_TABLE).
REQ-038 Settle (LUT_SETTLE_EN, SETTLE=4): out=1 steady; apply input 1 for 3 samples, input 0 for 1, input 1 for 4 -> out stays 1 until the 4th consecutive input-1 sample, then 0.

Source files
------------

// File: rtl/prog_truth_table_if.sv
// rtl/prog_truth_table_if.sv - serial table-load and evaluation signal bundle for prog_truth_table
interface prog_truth_table_if #(
  parameter int N_IN = 3
) ();
  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_ready;
  logic            cfg_done;
  logic            in_valid;
  logic [N_IN-1:0] in_bits;
  logic            out_valid;
  logic            out;

  modport master (
    output cfg_valid, cfg_bit, in_valid, in_bits,
    input  cfg_ready, cfg_done, out_valid, out
  );

  modport slave (
    input  cfg_valid, cfg_bit, in_valid, in_bits,
    output cfg_ready, cfg_done, out_valid, out
  );
endinterface

// File: rtl/prog_truth_table.sv
// rtl/prog_truth_table.sv - serially reprogrammable N_IN-input truth table with registered output
// Optional output settling filter enabled by LUT_SETTLE_EN.
module prog_truth_table #(
  parameter int                   N_IN        = 3,
  parameter logic [(2**N_IN)-1:0] RESET_TABLE = 8'hBE,
  parameter int                   SETTLE      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  prog_truth_table_if.slave    bus
);
  localparam int TBL = 2 ** N_IN;
  localparam int CW  = N_IN + 1;

  if (N_IN < 1 || N_IN > 6) begin : g_bad_n_in
    $error("prog_truth_table: N_IN out of range 1..6");
  end
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("prog_truth_table: SETTLE out of range 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TBL-1:0]  shadow_q, shadow_d;
  logic [TBL-1:0]  table_q, table_d;
  logic            cfg_ready_q, cfg_ready_d;
  logic            cfg_done_q, cfg_done_d;
  logic            out_valid_q, out_valid_d;
  logic            out_q, out_d;

  logic            accept;
  logic [N_IN-1:0] rev_idx;
  logic            raw;

  assign accept  = bus.cfg_valid && cfg_ready_q;
  // Table is stored MSB-first, so index i lives at bit TBL-1-i, i.e. the bitwise inverse.
  assign rev_idx = ~bus.in_bits;
  assign raw     = table_q[rev_idx];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    table_d  = table_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          shadow_d = {shadow_q[TBL-2:0], bus.cfg_bit};
          cnt_d    = cnt_q + CW'(1);
          state_d  = (cnt_q == CW'(TBL - 1)) ? COMMIT : LOAD;
        end
      end
      COMMIT: begin
        table_d = shadow_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cfg_ready_d = (state_d != COMMIT);
    cfg_done_d  = (state_d == COMMIT);
  end

`ifdef LUT_SETTLE_EN
  localparam logic [4:0] SETTLE_W = 5'(SETTLE);
  logic [3:0] settle_q, settle_d;

  always_comb begin
    out_valid_d = bus.in_valid;
    out_d       = out_q;
    settle_d    = settle_q;
    if (bus.in_valid) begin
      if (raw != out_q) begin
        if (({1'b0, settle_q} + 5'd1) >= SETTLE_W) begin
          out_d    = raw;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end else begin
        settle_d = '0;
      end
    end
    // A freshly committed table restarts the disagreement count.
    if (state_q == COMMIT) begin
      settle_d = '0;
    end
  end
`else
  always_comb begin
    out_valid_d = bus.in_valid;
    out_d       = bus.in_valid ? raw : out_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      table_q     <= RESET_TABLE;
      cfg_ready_q <= 1'b1;
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= 1'b0;
`ifdef LUT_SETTLE_EN
      settle_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      table_q     <= table_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_done_q  <= cfg_done_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
`ifdef LUT_SETTLE_EN
      settle_q    <= settle_d;
`endif
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
endmodule

// File: tb/tb_prog_truth_table.sv
// tb/tb_prog_truth_table.sv - scoreboard bench for prog_truth_table (LUT_SETTLE_EN selects settle scenario)
module tb_prog_truth_table;
  typedef bit seq_t[8];

  logic clk = 1'b0;
  logic rst;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   done_cnt = 0;
  bit   exp_q[$];

  always #5 clk = ~clk;

  prog_truth_table_if #(.N_IN(3)) bus ();

  prog_truth_table #(
    .N_IN(3),
    .RESET_TABLE(8'hBE),
    .SETTLE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    bit e;
    forever begin
      @(negedge clk);
      if (bus.cfg_done === 1'b1) done_cnt++;
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out", {31'd0, bus.out}, {31'd0, e});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      bus.in_valid  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
    chk("rst_cfg_done",  {31'd0, bus.cfg_done},  32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out",       {31'd0, bus.out},       32'd0);
  endtask

  task automatic eval1(input logic [2:0] b, input bit e);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_bits  = b;
    exp_q.push_back(e);
  endtask

  task automatic sweep(input seq_t seq);
    for (int i = 0; i < 8; i++) eval1(3'(i), seq[i]);
    idle(2);
  endtask

  // Loads val MSB-first, optionally pausing after stall_after bits, optionally
  // evaluating input 0 every cycle; checks cfg_done/cfg_ready cycle by cycle.
  task automatic run_load(input logic [7:0] val, input int stall_after, input int stall_len,
                          input bit eval_en, input bit old0, input bit new0);
    int sent       = 0;
    int stalled    = 0;
    int commit_cyc = -1;
    for (int c = 0; c < 8 + stall_len + 3; c++) begin
      @(posedge clk); #1;
      if (sent == stall_after && stalled < stall_len) begin
        bus.cfg_valid = 1'b0;
        stalled++;
      end else if (sent < 8) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = val[7-sent];
        sent++;
        if (sent == 8) commit_cyc = c + 1;
      end else begin
        bus.cfg_valid = 1'b0;
      end
      bus.in_valid = eval_en;
      bus.in_bits  = 3'd0;
      if (eval_en) exp_q.push_back((commit_cyc < 0 || c <= commit_cyc) ? old0 : new0);
      @(negedge clk);
      chk("cfg_done",  {31'd0, bus.cfg_done},  {31'd0, c == commit_cyc});
      chk("cfg_ready", {31'd0, bus.cfg_ready}, {31'd0, c != commit_cyc});
    end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    seq_t exp_be;
    seq_t exp_96;
    seq_t exp_01;
    int   done_before;
    exp_be = '{1, 0, 1, 1, 1, 1, 1, 0};
    exp_96 = '{1, 0, 0, 1, 0, 1, 1, 0};
    exp_01 = '{0, 0, 0, 0, 0, 0, 0, 1};

    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    fork
      monitor();
    join_none

    do_reset();

`ifdef LUT_SETTLE_EN
    repeat (3) eval1(3'd0, 1'b0);
    eval1(3'd0, 1'b1);
    repeat (3) eval1(3'd1, 1'b1);
    eval1(3'd0, 1'b1);
    repeat (3) eval1(3'd1, 1'b1);
    eval1(3'd1, 1'b0);
    idle(2);
`else
    sweep(exp_be);

    run_load(8'h96, -1, 0, 1'b0, 1'b0, 1'b0);
    sweep(exp_96);

    run_load(8'h01, 4, 3, 1'b0, 1'b0, 1'b0);
    sweep(exp_01);

    do_reset();
    run_load(8'h00, -1, 0, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a load, with cfg and eval activity held during reset.
    done_before = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = 1'b0;
    end
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bits  = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("midrst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    idle(10);
    chk("midrst_no_done", done_cnt, done_before);
    sweep(exp_be);
    run_load(8'h96, -1, 0, 1'b0, 1'b0, 1'b0);
    sweep(exp_96);
    chk("done_total", done_cnt, done_before + 1);
`endif

    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
